// File: rtl/counter_down_load.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Define COUNTER_DOWN_LOAD_AUTORELOAD_EN to reload from the captured start value instead of stopping at zero.
module counter_down_load #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] reload_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count      <= '0;
         tc         <= 1'b0;
         reload_reg <= '0;
      end else if (load) begin
         count      <= din;
         reload_reg <= din;
         tc         <= 1'b0;
         state_reg  <= (din != '0) ? RUN : DONE;
      end else begin
         tc <= 1'b0;
         case (state_reg)
            IDLE: count <= '0;
            RUN: begin
               if (en) begin
                  if (count > WIDTH'(1)) begin
                     count <= count - WIDTH'(1);
                  end else if (count == WIDTH'(1)) begin
                     // tc rises together with count reaching zero
                     count <= '0;
                     tc    <= 1'b1;
`ifndef COUNTER_DOWN_LOAD_AUTORELOAD_EN
                     state_reg <= DONE;
`endif
                  end else begin
`ifdef COUNTER_DOWN_LOAD_AUTORELOAD_EN
                     count <= reload_reg;
`else
                     count     <= '0;
                     state_reg <= DONE;
`endif
                  end
               end
            end
            DONE: count <= '0;
            default: begin
               state_reg <= IDLE;
               count     <= '0;
            end
         endcase
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench for counter_down_load: directed scenarios plus randomized traffic against a reference model.
// Honours COUNTER_DOWN_LOAD_AUTORELOAD_EN for the expected behaviour at count zero.
module tb_counter_down_load;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] count;
   logic         tc;
   logic         busy;
   logic         done;

   int n_vec = 0;
   int n_err = 0;

`ifdef COUNTER_DOWN_LOAD_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // Reference model: mode 0 = idle, 1 = running, 2 = finished
   logic [W-1:0] m_cnt = '0;
   logic [W-1:0] m_rel = '0;
   logic         m_tc = 1'b0;
   int           m_mode = 0;

   counter_down_load #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .en    (en),
      .din   (din),
      .count (count),
      .tc    (tc),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      if (rst) begin
         m_cnt = '0; m_rel = '0; m_tc = 1'b0; m_mode = 0;
      end else if (load) begin
         m_cnt = din; m_rel = din; m_tc = 1'b0;
         m_mode = (din != '0) ? 1 : 2;
      end else begin
         m_tc = 1'b0;
         if (m_mode == 1 && en) begin
            if (m_cnt == '0) begin
               m_cnt = m_rel;
            end else begin
               m_cnt = m_cnt - 3'd1;
               if (m_cnt == '0) begin
                  m_tc = 1'b1;
                  if (!AUTO) m_mode = 2;
               end
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance one edge, update the model, settle
   task automatic apply(input logic r, input logic l, input logic e, input logic [W-1:0] d);
      rst = r; load = l; en = e; din = d;
      @(posedge clk);
      model_edge();
      #1;
      $display("t=%0t rst=%0b load=%0b en=%0b din=%0d -> count=%0d tc=%0b busy=%0b done=%0b",
               $time, r, l, e, d, count, tc, busy, done);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b0, '0);
      n_vec++;
      if ({count, tc, busy, done} !== 6'b000_0_0_0) begin
         n_err++;
         $display("FAIL reset: count=%0d tc=%0b busy=%0b done=%0b, expected all zero", count, tc, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b1, W'($urandom));
         n_vec++;
         if ({count, tc, busy, done} !== {m_cnt, m_tc, m_mode == 1, m_mode == 2} || count !== '0) begin
            n_err++;
            $display("FAIL idle_en: count=%0d tc=%0b busy=%0b done=%0b, expected count=0 idle", count, tc, busy, done);
         end
      end
   endtask

   task automatic test_countdown();
      logic [W-1:0] exp_c;
      apply(1'b0, 1'b1, 1'b0, 3'd5);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) apply(1'b0, 1'b0, 1'b1, '0);
         exp_c = W'(5 - i);
         n_vec++;
         if (count !== exp_c || tc !== (i == 5) ||
             {count, tc, busy, done} !== {m_cnt, m_tc, m_mode == 1, m_mode == 2}) begin
            n_err++;
            $display("FAIL countdown[%0d]: count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b", i, count, tc, busy, done, exp_c, i == 5);
         end
      end
      apply(1'b0, 1'b0, 1'b1, '0);
      n_vec++;
      if ((AUTO && (count !== 3'd5 || busy !== 1'b1 || tc !== 1'b0)) ||
          (!AUTO && (count !== 3'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0))) begin
         n_err++;
         $display("FAIL after_zero: count=%0d tc=%0b busy=%0b done=%0b, expected %s", count, tc, busy, done,
                  AUTO ? "count=5 busy=1" : "count=0 done=1");
      end
   endtask

   task automatic test_en_toggle();
      logic [W-1:0] exp_c [5];
      exp_c = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd2};
      apply(1'b0, 1'b1, 1'b0, 3'd4);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) apply(1'b0, 1'b0, (i % 2) == 1, '0);
         n_vec++;
         if (count !== exp_c[i] || tc !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL en_toggle[%0d]: count=%0d tc=%0b busy=%0b, expected count=%0d tc=0 busy=1", i, count, tc, busy, exp_c[i]);
         end
      end
   endtask

   task automatic test_load_override();
      apply(1'b0, 1'b1, 1'b0, 3'd5);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, '0);
      n_vec++;
      if (count !== 3'd2) begin
         n_err++;
         $display("FAIL override_setup: count=%0d, expected 2", count);
      end
      apply(1'b0, 1'b1, 1'b1, 3'd6);
      n_vec++;
      if (count !== 3'd6 || busy !== 1'b1 || tc !== 1'b0 ||
          {count, tc, busy, done} !== {m_cnt, m_tc, m_mode == 1, m_mode == 2}) begin
         n_err++;
         $display("FAIL load_override: count=%0d tc=%0b busy=%0b, expected count=6 busy=1", count, tc, busy);
      end
   endtask

   task automatic test_reset_abort();
      apply(1'b0, 1'b1, 1'b0, 3'd5);
      apply(1'b0, 1'b0, 1'b1, '0);
      apply(1'b0, 1'b0, 1'b1, '0);
      apply(1'b1, 1'b0, 1'b1, '0);
      n_vec++;
      if ({count, tc, busy, done} !== 6'b000_0_0_0) begin
         n_err++;
         $display("FAIL reset_abort: count=%0d tc=%0b busy=%0b done=%0b, expected idle zero", count, tc, busy, done);
      end
      apply(1'b0, 1'b0, 1'b1, '0);
      n_vec++;
      if ({count, tc, busy, done} !== 6'b000_0_0_0) begin
         n_err++;
         $display("FAIL post_abort: count=%0d tc=%0b busy=%0b done=%0b, expected idle zero", count, tc, busy, done);
      end
   endtask

   task automatic test_load_zero_max();
      apply(1'b0, 1'b1, 1'b1, 3'd0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) apply(1'b0, 1'b0, 1'b1, '0);
         n_vec++;
         if (done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL load_zero[%0d]: count=%0d tc=%0b busy=%0b done=%0b, expected done=1 count=0", i, count, tc, busy, done);
         end
      end
      apply(1'b0, 1'b1, 1'b0, 3'd7);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) apply(1'b0, 1'b0, 1'b1, '0);
         n_vec++;
         if (count !== W'(7 - i) || tc !== (i == 7) ||
             {count, tc, busy, done} !== {m_cnt, m_tc, m_mode == 1, m_mode == 2}) begin
            n_err++;
            $display("FAIL load_max[%0d]: count=%0d tc=%0b, expected count=%0d tc=%0b", i, count, tc, 7 - i, i == 7);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) < 7, W'($urandom));
         n_vec++;
         if ({count, tc, busy, done} !== {m_cnt, m_tc, m_mode == 1, m_mode == 2}) begin
            n_err++;
            $display("FAIL random[%0d]: count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b",
                     i, count, tc, busy, done, m_cnt, m_tc, m_mode == 1, m_mode == 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_en_toggle();
      test_load_override();
      test_reset_abort();
      test_load_zero_max();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/counter_down_load.md
COUNTER_DOWN_LOAD -- requirements
Module: counter_down_load

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 3, counter and load-value width in bits.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-004 Port load SHALL be: load  input  1  capture din as start value and begin a countdown.
REQ-005 Port en SHALL be: en  input  1  count enable; while low, count and state hold.
REQ-006 Port din SHALL be: din  input  WIDTH  start/reload value, sampled only when load=1.
REQ-007 Port count SHALL be: count  output reg  WIDTH  current counter value.
REQ-008 Port tc SHALL be: tc  output reg  1  terminal-count pulse, one cycle.
REQ-009 Port busy SHALL be: busy  output  1  high exactly while state=RUN.
REQ-010 Port done SHALL be: done  output  1  high exactly while state=DONE.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 Input priority SHALL be rst > load > en.
REQ-013 load=1 in any state SHALL do all of the following at the next edge: count<=din, reload register<=din, tc<=0; state<=RUN if din!=0, else state<=DONE.
REQ-014 In IDLE with load=0, the block SHALL ignore en and hold count=0.
REQ-015 In RUN with en=1 and count>1, the block SHALL decrement count by 1 per edge.
REQ-016 In RUN with en=1 and count=1, the next edge SHALL set count<=0 and tc<=1, and tc SHALL be high for exactly one cycle, coincident with count=0.
REQ-017 With en=0, the block SHALL hold count and state and SHALL drive tc<=0.
REQ-018 Arithmetic SHALL be unsigned, modulo 2^WIDTH; the maximum start value is 2^WIDTH-1 (7 by default).
REQ-019 In DONE, the block SHALL hold count=0 and tc=0, ignore en, and leave DONE only on load or rst.
REQ-020 Outputs busy and done SHALL be decoded directly from the state register, with no extra latency.

Reset
REQ-021 When rst=1 at a rising edge, the next state SHALL be: state=IDLE, count=0, tc=0, busy=0, done=0, reload register=0.
REQ-022 A reset asserted mid-countdown SHALL abort the countdown at that edge, with no tc pulse.
REQ-023 The block SHALL have no asynchronous paths; an rst change between edges SHALL have no effect.

Configuration
REQ-024 Macro COUNTER_DOWN_LOAD_AUTORELOAD_EN SHALL select auto-reload mode at compile time.
REQ-025 Without the macro, the edge that produces count=0 (REQ-016) SHALL also set state<=DONE; this is one-shot mode.
REQ-026 With the macro, the block SHALL stay in RUN at count=0, and the next edge with en=1 SHALL set count<=reload register; the period is reload+1 enabled cycles, and DONE is reached only via load with din=0.
REQ-027 In both modes, load SHALL override any pending reload.

Verification
REQ-028 The bench SHALL cover these directed scenarios, using a 10 ns clock period:
- rst=1 for 100 ns, then rst=0 -> count=0, tc=0, busy=0, done=0, state IDLE; en=1 in IDLE leaves count=0.
- load din=5, then en=1 continuously -> count 5,4,3,2,1,0; tc high only in the count=0 cycle. One-shot: done=1, count holds 0. Auto-reload: count=5 on the following edge.
- load din=4, then en toggled 1,0,1,0 -> count decrements only on en=1 edges (4,3,3,2,2); tc stays 0.
- load and en both 1 with din=6 while count=2 in RUN -> count=6, no decrement that cycle.
- rst=1 while RUN at count=3 -> next edge count=0, state IDLE, no tc pulse.
- load din=0 -> done=1, busy=0, tc=0 in both modes; load din=7 -> counts 7 down to 0 with no wrap-around artefacts.
